// File: rtl/apb_gpio_bridge.sv
// APB slave front-end for the 8-bit GPIO register port; covers the GPIO read latency with wait states.
// Optional feature: define APB_GPIO_SLVERR_EN to report misses and read-only writes on PSLVERR.
module apb_gpio_bridge #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] GPIO_BASE = '0,
  parameter int                RD_WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              gpio_busw,
  output logic [1:0]        gpio_regsel,
  output logic [7:0]        gpio_wdata,
  input  logic [7:0]        gpio_rdata
);

  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

`ifdef APB_GPIO_SLVERR_EN
  localparam logic SLVERR_VAL = 1'b1;
`else
  localparam logic SLVERR_VAL = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WR, RDW, RDONE, ERR} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pready_reg;
  logic             pslverr_reg;
  logic [1:0]       regsel_reg;
  logic [7:0]       wdata_reg;

  logic setup;
  logic addr_hit;
  logic bad_xfer;

  assign setup    = PSEL & ~PENABLE;
  assign addr_hit = (PADDR[ADDR_W-1:2] == GPIO_BASE[ADDR_W-1:2]);
  // Offsets 0 (PIN) and 1 (reserved) are read-only.
  assign bad_xfer = ~addr_hit | (PWRITE & ~PADDR[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      regsel_reg  <= 2'b00;
      wdata_reg   <= 8'h00;
    end else begin
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (setup) begin
            regsel_reg <= PADDR[1:0];
            wdata_reg  <= PWDATA;
            if (bad_xfer) begin
              state_reg   <= ERR;
              pready_reg  <= 1'b1;
              pslverr_reg <= SLVERR_VAL;
            end else if (PWRITE) begin
              state_reg  <= WR;
              pready_reg <= 1'b1;
            end else begin
              state_reg <= RDW;
            end
          end
        end
        WR: state_reg <= IDLE;
        RDW: begin
          // A dropped PSEL mid-read abandons the transfer without a response.
          if (!PSEL) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= RDONE;
            cnt_reg    <= '0;
            pready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RDONE:   state_reg <= IDLE;
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // gpio_rdata is already registered inside the GPIO, so it is passed straight through.
  assign PRDATA      = (state_reg == RDONE) ? gpio_rdata : 8'h00;
  assign PREADY      = pready_reg;
  assign PSLVERR     = pslverr_reg;
  assign gpio_busw   = (state_reg == WR) & PSEL & PENABLE;
  assign gpio_regsel = regsel_reg;
  assign gpio_wdata  = wdata_reg;

endmodule

// File: tb/tb_apb_gpio_bridge.sv
// Bench for apb_gpio_bridge: two instances (RD_WAIT=1 and RD_WAIT=3), each with a GPIO register model.
module tb_apb_gpio_bridge;

`ifdef APB_GPIO_SLVERR_EN
  localparam bit SLV_EN = 1'b1;
`else
  localparam bit SLV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       psel [2];
  logic       penable [2];
  logic       pwrite [2];
  logic [7:0] paddr [2];
  logic [7:0] pwdata [2];
  logic [7:0] prdata [2];
  logic       pready [2];
  logic       pslverr [2];
  logic       busw [2];
  logic [1:0] regsel [2];
  logic [7:0] gwdata [2];
  logic [7:0] grdata [2] = '{8'h00, 8'h00};

  logic [7:0] dir_m [2]  = '{8'h00, 8'h00};
  logic [7:0] port_m [2] = '{8'h00, 8'h00};
  logic [7:0] pin_val;

  logic [7:0] ref_dir [2];
  logic [7:0] ref_port [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apb_gpio_bridge #(.ADDR_W(8), .GPIO_BASE(8'h00), .RD_WAIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .gpio_busw(busw[0]), .gpio_regsel(regsel[0]),
    .gpio_wdata(gwdata[0]), .gpio_rdata(grdata[0]));

  apb_gpio_bridge #(.ADDR_W(8), .GPIO_BASE(8'h00), .RD_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .gpio_busw(busw[1]), .gpio_regsel(regsel[1]),
    .gpio_wdata(gwdata[1]), .gpio_rdata(grdata[1]));

  // GPIO peripheral model: write strobe updates DIR/PORT, read data registered one cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busw[i]) begin
        case (regsel[i])
          2'd2:    dir_m[i] <= gwdata[i];
          2'd3:    port_m[i] <= gwdata[i];
          default: ;
        endcase
      end
      grdata[i] <= regsel[i][1] ? (regsel[i][0] ? port_m[i] : dir_m[i]) : pin_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rd_wait(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    #1;
    chk("idle_busw", 32'(busw[d]), 32'd0);
    chk("idle_pready", 32'(pready[d]), 32'd0);
  endtask

  // One APB transfer; expectations come from the register-map rules and the reference arrays.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [1:0] off;
    bit         miss, err;
    logic [7:0] exp_rd;
    int         exp_cyc, cyc, strobes;
    off = addr[1:0];
    miss = (addr[7:2] != 6'd0);
    err = miss || (wr && off < 2'd2);
    if (wr || err) exp_rd = 8'h00;
    else if (off == 2'd2) exp_rd = ref_dir[d];
    else if (off == 2'd3) exp_rd = ref_port[d];
    else exp_rd = pin_val;
    exp_cyc = (wr || err) ? 1 : rd_wait(d) + 1;

    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(negedge clk);
    penable[d] = 1'b1;
    cyc = 1;
    strobes = 0;
    #1;
    while (!pready[d] && cyc < 20) begin
      if (busw[d]) strobes++;
      if (prdata[d] !== 8'h00) chk("prdata_wait", 32'(prdata[d]), 32'd0);
      @(negedge clk);
      #1;
      cyc++;
    end
    if (busw[d]) strobes++;
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("prdata", 32'(prdata[d]), 32'(exp_rd));
    chk("pslverr", 32'(pslverr[d]), 32'(err && SLV_EN));
    chk("strobes", 32'(strobes), 32'((wr && !err) ? 1 : 0));
    chk("regsel", 32'(regsel[d]), 32'(off));
    chk("wdata", 32'(gwdata[d]), 32'(wd));
    $display("xfer dut%0d %s addr=%02h wdata=%02h prdata=%02h cycles=%0d pslverr=%0d",
             d, wr ? "WR" : "RD", addr, wd, prdata[d], cyc, pslverr[d]);
    if (wr && !err) begin
      if (off == 2'd2) ref_dir[d] = wd;
      else ref_port[d] = wd;
    end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk("rst_pready", 32'(pready[d]), 32'd0);
    chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
    chk("rst_prdata", 32'(prdata[d]), 32'd0);
    chk("rst_busw", 32'(busw[d]), 32'd0);
    chk("rst_regsel", 32'(regsel[d]), 32'd0);
    chk("rst_wdata", 32'(gwdata[d]), 32'd0);
  endtask

  initial begin
    int last_d;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h00; pwdata[i] = 8'h00;
      ref_dir[i] = 8'h00; ref_port[i] = 8'h00;
    end
    pin_val = 8'h3C;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge clk);
    rst = 1'b0;

    // Write DIR, zero-wait; busw low next cycle (checked by idle)
    xfer(0, 1'b1, 8'h02, 8'hF0);
    idle(0);
    // Write PORT then read it back
    xfer(0, 1'b1, 8'h03, 8'h5A);
    idle(0);
    xfer(0, 1'b0, 8'h03, 8'h00);
    idle(0);
    // Address miss, read and write
    xfer(0, 1'b0, 8'h40, 8'h00);
    idle(0);
    xfer(0, 1'b1, 8'h40, 8'h99);
    idle(0);
    // Write to read-only PIN, then read PIN
    xfer(0, 1'b1, 8'h00, 8'hFF);
    idle(0);
    xfer(0, 1'b0, 8'h00, 8'h00);
    idle(0);
    xfer(0, 1'b0, 8'h01, 8'h00);
    idle(0);

    // Reset asserted while a read is waiting
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h03; pwdata[0] = 8'h77;
    @(negedge clk);
    penable[0] = 1'b1;
    #1;
    chk("rdw_pready", 32'(pready[0]), 32'd0);
    chk("rdw_wdata", 32'(gwdata[0]), 32'h77);
    rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    #1;
    chk("rst_hold_pready", 32'(pready[0]), 32'd0);
    rst = 1'b0;
    xfer(0, 1'b1, 8'h03, 8'h11);
    idle(0);
    xfer(0, 1'b0, 8'h03, 8'h00);
    idle(0);

    // RD_WAIT=3 instance, back-to-back write then read
    xfer(1, 1'b1, 8'h02, 8'hAA);
    xfer(1, 1'b0, 8'h02, 8'h00);
    idle(1);

    // Randomized transfers against the reference arrays
    last_d = 1;
    for (int n = 0; n < 60; n++) begin
      int d;
      bit wr;
      logic [7:0] addr;
      logic [5:0] hi;
      d = int'($urandom_range(1, 0));
      wr = 1'($urandom_range(1, 0));
      hi = 6'($urandom_range(63, 1));
      addr = {6'd0, 2'($urandom_range(3, 0))};
      if ($urandom_range(3, 0) == 0) addr[7:2] = hi;
      if (d != last_d) idle(last_d);
      else if ($urandom_range(1, 0) == 1) idle(d);
      pin_val = 8'($urandom);
      xfer(d, wr, addr, 8'($urandom));
      last_d = d;
    end
    idle(last_d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
